// File: rtl/inst_prefetch_queue.sv
// Fetch stage: owns the fetch PC, issues reads to a 1-cycle synchronous ROM and
// queues returned instructions (tagged with their PC) for decode.
module inst_prefetch_queue #(
  parameter int PC_W   = 11,
  parameter int INST_W = 9,
  parameter int DEPTH  = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic                       Redirect,
  input  logic [PC_W-1:0]            RedirectPC,
  output logic [PC_W-1:0]            ImemAddr,
  output logic                       ImemRdEn,
  input  logic [INST_W-1:0]          ImemData,
  output logic                       InstValid,
  output logic [INST_W-1:0]          Inst,
  output logic [PC_W-1:0]            InstPC,
  input  logic                       InstReady,
  output logic [$clog2(DEPTH):0]     Count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0]                fetch_pc_q, fetch_pc_d;
  logic                           inflight_q, inflight_d;
  logic [PC_W-1:0]                inflight_pc_q, inflight_pc_d;
  logic [AW-1:0]                  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]                  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]                  count_q, count_d;
  logic [DEPTH-1:0][INST_W-1:0]   inst_mem_q, inst_mem_d;
  logic [DEPTH-1:0][PC_W-1:0]     pc_mem_q, pc_mem_d;

  logic          issue, push, pop;
  logic [CW:0]   occupancy;

  // A slot is reserved at issue time so the response can never overflow the FIFO.
  assign occupancy = {1'b0, count_q} + (CW+1)'(inflight_q);
  assign issue     = Reset & ~Start & ~Redirect & (occupancy < (CW+1)'(DEPTH));
  assign push      = inflight_q & ~Redirect;
  assign pop       = (count_q != '0) & InstReady;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    inst_mem_d    = inst_mem_q;
    pc_mem_d      = pc_mem_q;
    if (Redirect) begin
      fetch_pc_d = RedirectPC;
      inflight_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        fetch_pc_d    = fetch_pc_q + 1'b1;
        inflight_pc_d = fetch_pc_q;
      end
      if (push) begin
        inst_mem_d[wr_ptr_q] = ImemData;
        pc_mem_d[wr_ptr_q]   = inflight_pc_q;
        wr_ptr_d             = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      fetch_pc_q    <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset: head outputs are masked while the queue is empty.
  always_ff @(posedge Clk) begin
    inst_mem_q <= inst_mem_d;
    pc_mem_q   <= pc_mem_d;
  end

  assign ImemAddr  = fetch_pc_q;
  assign ImemRdEn  = issue;
  assign InstValid = (count_q != '0);
  assign Inst      = InstValid ? inst_mem_q[rd_ptr_q] : '0;
  assign InstPC    = InstValid ? pc_mem_q[rd_ptr_q] : '0;
  assign Count     = count_q;

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue with a behavioural 1-cycle ROM (ROM[i] = i + 0x100).
module tb_inst_prefetch_queue;
  logic        Clk = 1'b0;
  logic        Reset, Start, Redirect, InstReady;
  logic [10:0] RedirectPC;
  logic [10:0] ImemAddr;
  logic        ImemRdEn;
  logic [8:0]  ImemData = '0;
  logic        InstValid;
  logic [8:0]  Inst;
  logic [10:0] InstPC;
  logic [2:0]  Count;

  int vec = 0;
  int mis = 0;

  inst_prefetch_queue #(.PC_W(11), .INST_W(9), .DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Redirect(Redirect),
    .RedirectPC(RedirectPC), .ImemAddr(ImemAddr), .ImemRdEn(ImemRdEn),
    .ImemData(ImemData), .InstValid(InstValid), .Inst(Inst), .InstPC(InstPC),
    .InstReady(InstReady), .Count(Count)
  );

  always #5 Clk = ~Clk;

  function automatic logic [8:0] rom_f(input logic [10:0] a);
    logic [11:0] s;
    s = {1'b0, a} + 12'h100;
    return s[8:0];
  endfunction

  always @(posedge Clk) if (ImemRdEn) ImemData <= rom_f(ImemAddr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge Clk);
    #2;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(InstValid), 0);
    chk({tag, "_inst"},  32'(Inst), 0);
    chk({tag, "_pc"},    32'(InstPC), 0);
    chk({tag, "_rden"},  32'(ImemRdEn), 0);
    chk({tag, "_addr"},  32'(ImemAddr), 0);
    chk({tag, "_count"}, 32'(Count), 0);
  endtask

  // Expect n consecutive pops with PCs pc0, pc0+1, ... (wrapping) within a cycle budget.
  task automatic stream(input string tag, input logic [10:0] pc0, input int n);
    int k;
    logic [10:0] p;
    k = 0;
    for (int c = 0; c < 24 && k < n; c++) begin
      if (InstValid && InstReady) begin
        p = pc0 + 11'(k);
        chk({tag, "_pc"},   32'(InstPC), 32'(p));
        chk({tag, "_inst"}, 32'(Inst), 32'(rom_f(p)));
        k++;
      end
      nxt();
      #1;
    end
    chk({tag, "_len"}, k, n);
  endtask

  initial begin
    int issues;
    // 1: reset, then streaming from PC 0
    Reset = 0; Start = 0; Redirect = 0; RedirectPC = '0; InstReady = 1;
    nxt(); nxt(); #1;
    chk_zero("reset");
    Reset = 1; #1;
    chk("t1_rden0", 32'(ImemRdEn), 1);
    chk("t1_addr0", 32'(ImemAddr), 0);
    nxt(); #1;
    chk("t1_addr1", 32'(ImemAddr), 1);
    chk("t1_nvalid1", 32'(InstValid), 0);
    nxt(); #1;
    chk("t1_valid2", 32'(InstValid), 1);
    stream("t1", 11'h000, 6);

    // 2: backpressure from reset fills exactly DEPTH entries
    Reset = 0; InstReady = 0;
    nxt(); nxt();
    Reset = 1;
    issues = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (ImemRdEn) issues++;
      nxt();
    end
    #1;
    chk("t2_issues", issues, 4);
    chk("t2_count", 32'(Count), 4);
    chk("t2_rden", 32'(ImemRdEn), 0);
    chk("t2_addr", 32'(ImemAddr), 4);
    InstReady = 1; #1;
    stream("t2", 11'h000, 8);

    // 3: redirect with Count=3 and a read in flight
    Reset = 0; InstReady = 0;
    nxt();
    Reset = 1;
    nxt(); nxt(); nxt(); nxt(); #1;
    chk("t3_count3", 32'(Count), 3);
    Redirect = 1; RedirectPC = 11'h040; #1;
    chk("t3_rden_redir", 32'(ImemRdEn), 0);
    nxt();
    Redirect = 0; InstReady = 1; #1;
    chk("t3_count0", 32'(Count), 0);
    chk("t3_nvalid", 32'(InstValid), 0);
    chk("t3_addr", 32'(ImemAddr), 32'h040);
    chk("t3_rden", 32'(ImemRdEn), 1);
    nxt(); #1;
    chk("t3_stale", 32'(InstValid), 0);
    nxt(); #1;
    chk("t3_valid", 32'(InstValid), 1);
    chk("t3_pc", 32'(InstPC), 32'h040);
    chk("t3_inst", 32'(Inst), 32'h140);
    stream("t3", 11'h040, 4);

    // 4: redirect and pop in the same cycle
    chk("t4_valid_pre", 32'(InstValid), 1);
    Redirect = 1; RedirectPC = 11'h200; #1;
    nxt();
    Redirect = 0; #1;
    chk("t4_count0", 32'(Count), 0);
    chk("t4_nvalid", 32'(InstValid), 0);
    chk("t4_addr", 32'(ImemAddr), 32'h200);
    nxt(); nxt(); #1;
    chk("t4_valid", 32'(InstValid), 1);
    chk("t4_pc", 32'(InstPC), 32'h200);
    stream("t4", 11'h200, 3);

    // 5: PC wrap-around
    Redirect = 1; RedirectPC = 11'h7FE;
    nxt();
    Redirect = 0; #1;
    stream("t5", 11'h7FE, 4);

    // 6: hold one cycle after an issue
    Redirect = 1; RedirectPC = 11'h010;
    nxt();
    Redirect = 0; #1;
    chk("t6_rden_a", 32'(ImemRdEn), 1);
    chk("t6_addr_a", 32'(ImemAddr), 32'h010);
    nxt();
    Start = 1; #1;
    chk("t6_rden_hold", 32'(ImemRdEn), 0);
    chk("t6_addr_hold", 32'(ImemAddr), 32'h011);
    nxt(); #1;
    chk("t6_valid", 32'(InstValid), 1);
    chk("t6_pc", 32'(InstPC), 32'h010);
    chk("t6_rden_b", 32'(ImemRdEn), 0);
    nxt(); #1;
    chk("t6_nvalid", 32'(InstValid), 0);
    chk("t6_addr_b", 32'(ImemAddr), 32'h011);
    chk("t6_count", 32'(Count), 0);
    Start = 0; #1;
    chk("t6_resume", 32'(ImemRdEn), 1);
    stream("t6", 11'h011, 3);

    // 7: reset mid-operation with Count=2 and a read in flight
    Reset = 0; InstReady = 0;
    nxt();
    Reset = 1;
    nxt(); nxt(); nxt(); #1;
    chk("t7_count2", 32'(Count), 2);
    Reset = 0; #1;
    chk("t7_rden_rst", 32'(ImemRdEn), 0);
    nxt(); #1;
    chk_zero("t7_reset");
    Reset = 1; InstReady = 1; #1;
    chk("t7_rden", 32'(ImemRdEn), 1);
    chk("t7_addr", 32'(ImemAddr), 0);
    nxt(); nxt(); #1;
    chk("t7_valid", 32'(InstValid), 1);
    chk("t7_pc", 32'(InstPC), 0);
    chk("t7_inst", 32'(Inst), 32'h100);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
